sequenciador_instrucao: RTL

Fetch/step sequencer upstream of `unidade_controle`. It owns the program counter and drives the synchronous instruction memory (`memoram`). It holds the instruction register and generates the `Tstep` count that `unidade_controle` decodes. It consumes that unit's `IRin`/`Done`/`Clear` outputs and returns `Instrucao`, `Tstep` and `DIN`, so each instruction runs from a Run request to Done.

---
 rtl/seq_pkg.sv | 20 ++
 rtl/contador_tstep.sv | 24 ++
 rtl/sequenciador_instrucao.sv | 137 +++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared states, T-step codes and opcodes for the instruction sequencer.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } seqState_t;

  localparam logic [1:0] T0 = 2'd0;
  localparam logic [1:0] T1 = 2'd1;
  localparam logic [1:0] T2 = 2'd2;
  localparam logic [1:0] T3 = 2'd3;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

endpackage

// File: rtl/contador_tstep.sv
// 2-bit T-step counter; the synchronous clear takes priority over the enable.
module contador_tstep (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clear_i,
  input  logic       enable_i,
  output logic [1:0] count_o
);

  logic [1:0] count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= 2'b00;
    end else if (clear_i) begin
      count_q <= 2'b00;
    end else if (enable_i) begin
      count_q <= count_q + 2'd1;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/sequenciador_instrucao.sv
// Fetch/step sequencer: owns PC and IR, drives memoram and the Tstep count.
// SEQ_AUTO_RUN_EN: keep fetching back-to-back while Run stays high.
module sequenciador_instrucao
  import seq_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 9,
  parameter int PROG_LEN = 32
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Run,
  input  logic              IRin,
  input  logic              Done,
  input  logic              Clear,
  input  logic [DATA_W-1:0] MemData,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemRd,
  output logic [DATA_W-1:0] DIN,
  output logic [DATA_W-1:0] Instrucao,
  output logic [1:0]        Tstep,
  output logic              Busy,
  output logic              IllegalOp
);

  localparam logic [ADDR_W:0] PROG_LEN_W = (ADDR_W+1)'(PROG_LEN);

  seqState_t         state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [DATA_W-1:0] ir_q;
  logic              runPrev_q;
  logic              busy_q;
  logic              illegal_q;
  logic [1:0]        tstep;

  logic start;
  logic inExec;
  logic inT0;
  logic isMvi;
  logic instrEnd;
  logic timeout;
  logic goAgain;
  logic cntClear;

  // PC arithmetic modulo the program length; a < PROG_LEN so one fold suffices.
  function automatic logic [ADDR_W-1:0] addWrap(input logic [ADDR_W-1:0] a,
                                                 input logic [1:0]        inc);
    logic [ADDR_W:0] sum;
    sum = {1'b0, a} + {{(ADDR_W-1){1'b0}}, inc};
    if (sum >= PROG_LEN_W) begin
      sum = sum - PROG_LEN_W;
    end
    return sum[ADDR_W-1:0];
  endfunction

  assign start    = Run & ~runPrev_q;
  assign inExec   = (state_q == EXEC);
  assign inT0     = inExec && (tstep == T0);
  assign isMvi    = (MemData[DATA_W-1 -: 3] == OP_MVI);
  assign instrEnd = inExec && Done && (tstep != T0);
  assign timeout  = inExec && (tstep == T3) && !Done;
  assign cntClear = !inExec || Clear || instrEnd || timeout;

`ifdef SEQ_AUTO_RUN_EN
  assign goAgain = Run;
`else
  assign goAgain = 1'b0;
`endif

  // The mvi immediate must be requested in T0 itself, so address/strobe follow MemData.
  always_comb begin
    MemAddr = pc_q;
    MemRd   = 1'b0;
    if (state_q == FETCH) begin
      MemRd = 1'b1;
    end else if (inT0 && isMvi) begin
      MemAddr = addWrap(pc_q, 2'd1);
      MemRd   = 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      runPrev_q <= 1'b0;
      busy_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      runPrev_q <= Run;
      illegal_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= FETCH;
            busy_q  <= 1'b1;
          end
        end
        FETCH: begin
          state_q <= EXEC;
        end
        EXEC: begin
          if (inT0 && IRin) begin
            ir_q <= MemData;
            pc_q <= addWrap(pc_q, isMvi ? 2'd2 : 2'd1);
          end
          // A timeout retires the instruction as a NOP; its PC advance stands.
          if (instrEnd || timeout) begin
            illegal_q <= timeout;
            state_q   <= goAgain ? FETCH : IDLE;
            busy_q    <= goAgain;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  contador_tstep uTstep (
    .clk_i    (Clock),
    .rst_ni   (Resetn),
    .clear_i  (cntClear),
    .enable_i (inExec),
    .count_o  (tstep)
  );

  assign Tstep     = tstep;
  assign DIN       = MemData;
  assign Instrucao = ir_q;
  assign Busy      = busy_q;
  assign IllegalOp = illegal_q;

endmodule
